// File: rtl/n64_region_decoder.sv
// n64_region_decoder: runtime-programmable table of N64 address windows feeding a 2-stage
// translate pipeline. Define DECODER_MISS_LOG_EN to add the sticky first-miss capture ports.
module n64_region_decoder #(
  parameter int NUM_REGIONS = 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int OUT_WIDTH   = 26,
  parameter int BANK_WIDTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_cfg_write,
  input  logic [3:0]            i_cfg_index,
  input  logic [1:0]            i_cfg_field,
  input  logic [ADDR_WIDTH-1:0] i_cfg_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [BANK_WIDTH-1:0] o_bank,
  output logic [OUT_WIDTH-1:0]  o_translated_address,
  output logic                  o_bank_prefetch,
  output logic                  o_hit
`ifdef DECODER_MISS_LOG_EN
  ,
  output logic                  o_miss_flag,
  output logic [ADDR_WIDTH-1:0] o_miss_address
`endif
);

  localparam logic [BANK_WIDTH-1:0] BANK_INVALID = '1;

  // Region table
  logic [ADDR_WIDTH-1:0] base_q   [NUM_REGIONS];
  logic [ADDR_WIDTH-1:0] base_d   [NUM_REGIONS];
  logic [ADDR_WIDTH-1:0] mask_q   [NUM_REGIONS];
  logic [ADDR_WIDTH-1:0] mask_d   [NUM_REGIONS];
  logic [OUT_WIDTH-1:0]  offset_q [NUM_REGIONS];
  logic [OUT_WIDTH-1:0]  offset_d [NUM_REGIONS];
  logic [BANK_WIDTH-1:0] bank_q   [NUM_REGIONS];
  logic [BANK_WIDTH-1:0] bank_d   [NUM_REGIONS];
  logic                  en_q     [NUM_REGIONS];
  logic                  en_d     [NUM_REGIONS];
  logic                  pf_q     [NUM_REGIONS];
  logic                  pf_d     [NUM_REGIONS];

  // Winner of the combinational lookup
  logic                  win_hit;
  logic [ADDR_WIDTH-1:0] win_mask;
  logic [OUT_WIDTH-1:0]  win_offset;
  logic [BANK_WIDTH-1:0] win_bank;
  logic                  win_pf;

  // Pipeline stages
  logic                  s1_valid_q, s1_valid_d;
  logic [OUT_WIDTH-1:0]  s1_xaddr_q, s1_xaddr_d;
  logic [OUT_WIDTH-1:0]  s1_offset_q, s1_offset_d;
  logic [BANK_WIDTH-1:0] s1_bank_q, s1_bank_d;
  logic                  s1_pf_q, s1_pf_d;
  logic                  s1_hit_q, s1_hit_d;
  logic                  out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]  out_addr_q, out_addr_d;
  logic [BANK_WIDTH-1:0] out_bank_q, out_bank_d;
  logic                  out_pf_q, out_pf_d;
  logic                  out_hit_q, out_hit_d;
  logic                  stall;

  always_comb begin
    for (int i = 0; i < NUM_REGIONS; i++) begin
      base_d[i]   = base_q[i];
      mask_d[i]   = mask_q[i];
      offset_d[i] = offset_q[i];
      bank_d[i]   = bank_q[i];
      en_d[i]     = en_q[i];
      pf_d[i]     = pf_q[i];
    end
    if (i_cfg_write && (int'(i_cfg_index) < NUM_REGIONS)) begin
      case (i_cfg_field)
        2'd0: base_d[i_cfg_index]   = i_cfg_data;
        2'd1: mask_d[i_cfg_index]   = i_cfg_data;
        2'd2: offset_d[i_cfg_index] = i_cfg_data[OUT_WIDTH-1:0];
        default: begin
          en_d[i_cfg_index]   = i_cfg_data[0];
          pf_d[i_cfg_index]   = i_cfg_data[1];
          bank_d[i_cfg_index] = i_cfg_data[4 +: BANK_WIDTH];
        end
      endcase
    end
  end

  // Ascending scan so the highest matching index is the one left standing.
  always_comb begin
    win_hit    = 1'b0;
    win_mask   = '0;
    win_offset = '0;
    win_bank   = BANK_INVALID;
    win_pf     = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (en_q[i] && ((i_address & ~mask_q[i]) == (base_q[i] & ~mask_q[i]))) begin
        win_hit    = 1'b1;
        win_mask   = mask_q[i];
        win_offset = offset_q[i];
        win_bank   = bank_q[i];
        win_pf     = pf_q[i];
      end
    end
  end

  // Handshake: a request moves in on i_valid && o_ready and a result moves out on
  // o_valid && i_ready; while a result waits (o_valid && !i_ready) both stages freeze.
  assign stall   = out_valid_q && !i_ready;
  assign o_ready = !stall;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_xaddr_d  = s1_xaddr_q;
    s1_offset_d = s1_offset_q;
    s1_bank_d   = s1_bank_q;
    s1_pf_d     = s1_pf_q;
    s1_hit_d    = s1_hit_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_bank_d  = out_bank_q;
    out_pf_d    = out_pf_q;
    out_hit_d   = out_hit_q;
    if (!stall) begin
      s1_valid_d  = i_valid;
      s1_xaddr_d  = OUT_WIDTH'(i_address & win_mask);
      s1_offset_d = win_offset;
      s1_bank_d   = win_bank;
      s1_pf_d     = win_pf;
      s1_hit_d    = win_hit;
      out_valid_d = s1_valid_q;
      out_addr_d  = s1_xaddr_q + s1_offset_q;
      out_bank_d  = s1_bank_q;
      out_pf_d    = s1_pf_q;
      out_hit_d   = s1_hit_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        base_q[i]   <= '0;
        mask_q[i]   <= '0;
        offset_q[i] <= '0;
        bank_q[i]   <= '0;
        en_q[i]     <= 1'b0;
        pf_q[i]     <= 1'b0;
      end
      s1_valid_q  <= 1'b0;
      s1_xaddr_q  <= '0;
      s1_offset_q <= '0;
      s1_bank_q   <= BANK_INVALID;
      s1_pf_q     <= 1'b0;
      s1_hit_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_bank_q  <= BANK_INVALID;
      out_pf_q    <= 1'b0;
      out_hit_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        base_q[i]   <= base_d[i];
        mask_q[i]   <= mask_d[i];
        offset_q[i] <= offset_d[i];
        bank_q[i]   <= bank_d[i];
        en_q[i]     <= en_d[i];
        pf_q[i]     <= pf_d[i];
      end
      s1_valid_q  <= s1_valid_d;
      s1_xaddr_q  <= s1_xaddr_d;
      s1_offset_q <= s1_offset_d;
      s1_bank_q   <= s1_bank_d;
      s1_pf_q     <= s1_pf_d;
      s1_hit_q    <= s1_hit_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_bank_q  <= out_bank_d;
      out_pf_q    <= out_pf_d;
      out_hit_q   <= out_hit_d;
    end
  end

  assign o_valid              = out_valid_q;
  assign o_bank               = out_bank_q;
  assign o_translated_address = out_addr_q;
  assign o_bank_prefetch      = out_pf_q;
  assign o_hit                = out_hit_q;

`ifdef DECODER_MISS_LOG_EN
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic                  miss_flag_q, miss_flag_d;
  logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
  logic                  miss_clear;

  assign miss_clear = i_cfg_write && (i_cfg_index == 4'd15) && (i_cfg_field == 2'd3);

  // Only the first miss entering the output stage is kept; the clear strobe overrides it.
  always_comb begin
    s1_addr_d   = stall ? s1_addr_q : i_address;
    miss_flag_d = miss_flag_q;
    miss_addr_d = miss_addr_q;
    if (!stall && s1_valid_q && !s1_hit_q && !miss_flag_q) begin
      miss_flag_d = 1'b1;
      miss_addr_d = s1_addr_q;
    end
    if (miss_clear) begin
      miss_flag_d = 1'b0;
      miss_addr_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_addr_q   <= '0;
      miss_flag_q <= 1'b0;
      miss_addr_q <= '0;
    end else begin
      s1_addr_q   <= s1_addr_d;
      miss_flag_q <= miss_flag_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  assign o_miss_flag    = miss_flag_q;
  assign o_miss_address = miss_addr_q;
`endif

endmodule
